edge_frame_ctrl: RTL and testbench

EDGE_FRAME_CTRL -- requirements
Module: edge_frame_ctrl

---
 rtl/edge_frame_ctrl.sv | 132 +++++++++++++
 tb/tb_edge_frame_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_frame_ctrl.sv
// edge_frame_ctrl: frame sequencer between a raster pixel source,
// a 5x5 edge filter and a downstream sink with valid/ready.
module edge_frame_ctrl #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       src_valid,
  input  logic [3:0] src_pixel,
  output logic       src_ready,
  output logic [3:0] flt_pixel,
  output logic       flt_advance,
  input  logic [3:0] flt_result,
  output logic       dst_valid,
  output logic [3:0] dst_pixel,
  output logic       dst_last,
  input  logic       dst_ready,
  output logic       busy,
  output logic       frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  localparam logic [CW-1:0] COL_MAX  = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_MAX  = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_EDGE = CW'(4);
  localparam logic [RW-1:0] ROW_EDGE = RW'(4);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_col;
  logic [CW-1:0]   w_col_nxt;
  logic [RW-1:0]   r_row;
  logic [RW-1:0]   w_row_nxt;
  logic            r_dst_valid;
  logic            w_dv_nxt;
  logic            r_dst_last;
  logic            w_last_nxt;

  logic            w_at_end;
  logic            w_col_end;
  logic            w_interior;

  // Position of the pixel currently offered by the source.
  assign w_col_end  = (r_col == COL_MAX);
  assign w_at_end   = w_col_end && (r_row == ROW_MAX);
  // The 5x5 window is fully inside this frame only from (4,4) onward;
  // this also masks stale line-buffer data from an earlier frame.
  assign w_interior = (r_row >= ROW_EDGE) && (r_col >= COL_EDGE);

  assign flt_pixel = src_pixel;
  assign dst_pixel = flt_result;
  assign dst_valid = r_dst_valid;
  assign dst_last  = r_dst_last;

  // State, counters and output flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_col       <= '0;
      r_row       <= '0;
      r_dst_valid <= 1'b0;
      r_dst_last  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_col       <= w_col_nxt;
      r_row       <= w_row_nxt;
      r_dst_valid <= w_dv_nxt;
      r_dst_last  <= w_last_nxt;
    end
  end

  // Next-state, counter stepping and handshake outputs
  always_comb begin
    w_state_nxt = r_state;
    w_col_nxt   = r_col;
    w_row_nxt   = r_row;
    // An unconsumed output stays put; a consumed one drops.
    w_dv_nxt    = r_dst_valid & ~dst_ready;
    w_last_nxt  = r_dst_last & ~dst_ready;
    src_ready   = 1'b0;
    flt_advance = 1'b0;
    frame_done  = 1'b0;
    busy        = (r_state != S_IDLE);
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_RUN;
          w_col_nxt   = '0;
          w_row_nxt   = '0;
        end
      end
      S_RUN: begin
        src_ready   = ~r_dst_valid | dst_ready;
        flt_advance = src_valid & src_ready;
        if (flt_advance) begin
          w_dv_nxt   = w_interior;
          w_last_nxt = w_interior & w_at_end;
          if (w_at_end) begin
            w_state_nxt = S_DRAIN;
            w_col_nxt   = '0;
            w_row_nxt   = '0;
          end else if (w_col_end) begin
            w_col_nxt = '0;
            w_row_nxt = r_row + RW'(1);
          end else begin
            w_col_nxt = r_col + CW'(1);
          end
        end
      end
      S_DRAIN: begin
        if (r_dst_valid && dst_ready && r_dst_last) begin
          frame_done  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_edge_frame_ctrl.sv
// tb_edge_frame_ctrl: vector table plus model-checked frames
// for edge_frame_ctrl with an 8x6 image.
module tb_edge_frame_ctrl;

  localparam int W = 8;
  localparam int H = 6;
  localparam int N = W * H;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       src_valid;
  logic [3:0] src_pixel;
  logic       src_ready;
  logic [3:0] flt_pixel;
  logic       flt_advance;
  logic [3:0] flt_result;
  logic       dst_valid;
  logic [3:0] dst_pixel;
  logic       dst_last;
  logic       dst_ready;
  logic       busy;
  logic       frame_done;

  edge_frame_ctrl #(.IMG_W(W), .IMG_H(H)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .src_valid  (src_valid),
    .src_pixel  (src_pixel),
    .src_ready  (src_ready),
    .flt_pixel  (flt_pixel),
    .flt_advance(flt_advance),
    .flt_result (flt_result),
    .dst_valid  (dst_valid),
    .dst_pixel  (dst_pixel),
    .dst_last   (dst_last),
    .dst_ready  (dst_ready),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Stand-in filter: output changes only when the filter is advanced.
  always @(posedge clk) begin
    if (flt_advance) flt_result <= src_pixel ^ 4'hA;
  end

  typedef struct packed {
    logic rst, st, sv, dr;
    logic busy, srdy, adv, dv, fd;
  } vec_t;

  vec_t tbl [9];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  // Reference model: frame progress as pixel index, pending output.
  int m_active = 0;
  int m_acc = 0;
  int m_pend = 0;
  int m_pidx = 0;
  logic [3:0] m_ppix = 4'h0;

  // Observations of the DUT for the current frame.
  int d_adv, d_outs, d_adv37, d_first_dv, d_seen_dv;
  int d_first_adv, d_last_adv;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic cycle();
    logic e_srdy, e_adv, e_last, e_fd;
    int idx, was;
    @(negedge clk);
    e_srdy = (m_active != 0) && (m_acc < N) &&
             (m_pend == 0 || dst_ready);
    e_adv  = e_srdy && src_valid;
    e_last = (m_pend != 0) && (m_pidx == N - 1);
    e_fd   = e_last && dst_ready;
    chk("busy", 32'(busy), 32'(m_active != 0));
    chk("src_ready", 32'(src_ready), 32'(e_srdy));
    chk("flt_advance", 32'(flt_advance), 32'(e_adv));
    chk("dst_valid", 32'(dst_valid), 32'(m_pend != 0));
    chk("dst_last", 32'(dst_last), 32'(e_last));
    chk("frame_done", 32'(frame_done), 32'(e_fd));
    chk("flt_pixel", 32'(flt_pixel), 32'(src_pixel));
    if (m_pend != 0) chk("dst_pixel", 32'(dst_pixel), 32'(m_ppix));
    if (flt_advance) begin
      d_adv++;
      if (d_adv == 1) d_first_adv = cyc;
      d_last_adv = cyc;
      if (d_adv == 37) d_adv37 = cyc;
    end
    if (dst_valid && d_seen_dv == 0) begin
      d_seen_dv  = 1;
      d_first_dv = cyc;
    end
    if (dst_valid && dst_ready) d_outs++;
    if (rst) begin
      m_active = 0;
      m_acc    = 0;
      m_pend   = 0;
    end else begin
      was = m_active;
      if (m_pend != 0 && dst_ready) begin
        if (m_pidx == N - 1) m_active = 0;
        m_pend = 0;
      end
      if (e_adv) begin
        idx = m_acc;
        m_acc++;
        if (idx / W >= 4 && idx % W >= 4) begin
          m_pend = 1;
          m_pidx = idx;
          m_ppix = src_pixel ^ 4'hA;
        end
      end
      if (was == 0 && start) begin
        m_active = 1;
        m_acc    = 0;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic go(input bit r, input bit st, input bit sv,
                    input bit dr);
    rst       = r;
    start     = st;
    src_valid = sv;
    dst_ready = dr;
    src_pixel = 4'($urandom);
    cycle();
  endtask

  task automatic clr_obs();
    d_adv       = 0;
    d_outs      = 0;
    d_seen_dv   = 0;
    d_adv37     = -100;
    d_first_dv  = -200;
    d_first_adv = 0;
    d_last_adv  = 0;
  endtask

  task automatic run_frame(input int sv_pct, input int dr_pct,
                           input bit stall, input bit start_mid);
    int k, sn, a0;
    bit sv, dr, st;
    clr_obs();
    go(1'b0, 1'b1, 1'b1, 1'b1);
    k  = 0;
    sn = 0;
    while (m_active != 0 && k < 600) begin
      sv = ($urandom_range(99) < sv_pct);
      dr = ($urandom_range(99) < dr_pct);
      st = start_mid && (m_acc == 10);
      a0 = d_adv;
      if (stall && m_pend != 0 && sn < 10) begin
        dr = 1'b0;
        sv = 1'b1;
        sn++;
        go(1'b0, st, sv, dr);
        chk("stall_no_advance", d_adv - a0, 0);
      end else begin
        go(1'b0, st, sv, dr);
      end
      k++;
    end
    if (k >= 600) chk("frame_timeout", 1, 0);
    if (stall) chk("stall_cycles", sn, 10);
    chk("out_count", d_outs, (W - 4) * (H - 4));
    chk("in_count", d_adv, N);
    chk("first_dv_latency", d_first_dv - d_adv37, 1);
    if (sv_pct >= 100 && dr_pct >= 100 && !stall)
      chk("consecutive_in", d_last_adv - d_first_adv, N - 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    rst       = 1'b1;
    start     = 1'b0;
    src_valid = 1'b0;
    src_pixel = 4'h0;
    dst_ready = 1'b1;
    // rst st sv dr | busy srdy adv dv fd
    tbl[0] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 9; i++) begin
      rst       = tbl[i].rst;
      start     = tbl[i].st;
      src_valid = tbl[i].sv;
      dst_ready = tbl[i].dr;
      src_pixel = 4'($urandom);
      @(negedge clk);
      chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
      chk($sformatf("tbl%0d_src_ready", i), 32'(src_ready),
          32'(tbl[i].srdy));
      chk($sformatf("tbl%0d_flt_advance", i), 32'(flt_advance),
          32'(tbl[i].adv));
      chk($sformatf("tbl%0d_dst_valid", i), 32'(dst_valid),
          32'(tbl[i].dv));
      chk($sformatf("tbl%0d_frame_done", i), 32'(frame_done),
          32'(tbl[i].fd));
      @(posedge clk);
      #1;
    end

    go(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (3) go(1'b0, 1'b0, 1'b1, 1'b1);

    // Full-rate frame, stalled frame, 50% source, start during RUN.
    run_frame(100, 100, 1'b0, 1'b0);
    run_frame(100, 100, 1'b1, 1'b0);
    run_frame(50, 100, 1'b0, 1'b0);
    run_frame(100, 100, 1'b0, 1'b1);

    // Reset in the middle of a frame.
    clr_obs();
    go(1'b0, 1'b1, 1'b1, 1'b1);
    k = 0;
    while (d_adv < 20 && k < 100) begin
      go(1'b0, 1'b0, 1'b1, 1'b1);
      k++;
    end
    chk("rst_pre_in_count", d_adv, 20);
    go(1'b1, 1'b0, 1'b1, 1'b1);
    repeat (2) go(1'b0, 1'b0, 1'b1, 1'b1);
    run_frame(100, 100, 1'b0, 1'b0);

    // Back-to-back frames, then random source and sink.
    run_frame(100, 100, 1'b0, 1'b0);
    run_frame(70, 60, 1'b0, 1'b0);
    run_frame(40, 50, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
